// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: WIDTH x WIDTH signed product on HI/LO, start/done handshake.
// Define UNSIGNED_MUL_EN to add the is_unsigned port (zero-extended operands, one extra step).
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
`ifdef UNSIGNED_MUL_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] mp,
    input  logic [WIDTH-1:0] mc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned ITER = WIDTH / 2;
    localparam int unsigned AW   = WIDTH + 2;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_S = CW'(ITER - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    mpr_q;
    logic             bm1_q;
    logic [AW-1:0]    mcx_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             ext_bit;

    logic [2:0]         triplet;
    logic [AW-1:0]      mc2;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      acc_nxt;
    logic [AW-1:0]      mpr_nxt;
    logic [2*AW-1:0]    full_nxt;
    logic [2*WIDTH-1:0] prod;
    logic               last;

`ifdef UNSIGNED_MUL_EN
    localparam logic [CW-1:0] LAST_U = CW'(ITER);
    logic uns_q;
    assign ext_bit = ~is_unsigned;
`else
    assign ext_bit = 1'b1;
`endif

    always_comb begin
        triplet = {mpr_q[1:0], bm1_q};
        mc2     = {mcx_q[AW-2:0], 1'b0};
        addend  = '0;
        unique case (triplet)
            3'b001, 3'b010: addend = mcx_q;
            3'b011:         addend = mc2;
            3'b100:         addend = ~mc2 + AW'(1);
            3'b101, 3'b110: addend = ~mcx_q + AW'(1);
            default:        addend = '0;
        endcase
        sum      = acc_q + addend;
        acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        mpr_nxt  = {sum[1:0], mpr_q[AW-1:2]};
        full_nxt = {acc_nxt, mpr_nxt};
`ifdef UNSIGNED_MUL_EN
        // Unsigned runs one extra step, so no multiplier bits are left over in mpr.
        last = (count_q == (uns_q ? LAST_U : LAST_S));
        prod = uns_q ? (2*WIDTH)'(full_nxt) : (2*WIDTH)'(full_nxt >> 2);
`else
        last = (count_q == LAST_S);
        prod = (2*WIDTH)'(full_nxt >> 2);
`endif
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mpr_q   <= '0;
            bm1_q   <= 1'b0;
            mcx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef UNSIGNED_MUL_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcx_q   <= {{2{mc[WIDTH-1] & ext_bit}}, mc};
                        mpr_q   <= {{2{mp[WIDTH-1] & ext_bit}}, mp};
                        bm1_q   <= 1'b0;
                        acc_q   <= '0;
                        count_q <= '0;
`ifdef UNSIGNED_MUL_EN
                        uns_q   <= is_unsigned;
`endif
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_nxt;
                    mpr_q   <= mpr_nxt;
                    bm1_q   <= mpr_q[1];
                    count_q <= count_q + CW'(1);
                    if (last) begin
                        hi_q    <= prod[2*WIDTH-1:WIDTH];
                        lo_q    <= prod[WIDTH-1:0];
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: products checked against a multiply-operator scoreboard.
module tb_booth_mul_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mp = '0;
    logic [31:0] mc = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef UNSIGNED_MUL_EN
    logic        uns = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    always #5 clock = ~clock;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
`ifdef UNSIGNED_MUL_EN
        .is_unsigned(uns),
`endif
        .mp         (mp),
        .mc         (mc),
        .busy       (busy),
        .done       (done),
        .HI         (HI),
        .LO         (LO)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic u);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (u) return {32'b0, a} * {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic u, input bit disturb, input int exp_lat);
        int lat;
        int busy_cnt;
        logic [63:0] exp;
        mp = a;
        mc = b;
`ifdef UNSIGNED_MUL_EN
        uns = u;
`endif
        start = 1'b1;
        sb_q.push_back(model(a, b, u));
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        mp = $urandom;
        mc = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (disturb && lat == 4) begin
                start = 1'b1;
                mp = 32'd5;
                mc = 32'd9;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        if (done) check({tag, "_product"}, {HI, LO}, exp);
        @(negedge clock);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cnt;
        int gap;
        logic [63:0] exp;

        // Reset
        @(negedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        clear = 1'b0;
        @(negedge clock);

        // Directed products
        run_op("zero", 32'h0, 32'h0, 1'b0, 1'b0, 17);
        run_op("m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 17);
        check("m1m1_const", {HI, LO}, 64'h0000000000000001);
        run_op("m4x2", 32'hFFFFFFFC, 32'h00000002, 1'b0, 1'b0, 17);
        check("m4x2_const", {HI, LO}, 64'hFFFFFFFFFFFFFFF8);
        run_op("minmin", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 17);
        check("minmin_const", {HI, LO}, 64'h4000000000000000);
        run_op("maxmin", 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 17);
        run_op("onemin", 32'h00000001, 32'h80000000, 1'b0, 1'b0, 17);
        run_op("minmax", 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 17);
        for (int i = 0; i < 6; i++) run_op("rand", $urandom, $urandom, 1'b0, 1'b0, 17);

        // start re-pulsed mid-run with new operands: ignored
        run_op("repulse", 32'd7, 32'd3, 1'b0, 1'b1, 17);
        check("repulse_const", {HI, LO}, 64'h15);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) cnt++;
        end
        check("repulse_no_extra_done", 64'(cnt), 64'd0);

        // Asynchronous clear mid-run
        mp = 32'd7;
        mc = 32'd3;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        #2 clear = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_hilo", {HI, LO}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done || busy) cnt++;
        end
        check("clr_no_done", 64'(cnt), 64'd0);
        run_op("after_clr", 32'd7, 32'd3, 1'b0, 1'b0, 17);

        // clear and start together: clear wins
        clear = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        check("clr_start_busy", 64'(busy), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("clr_start_idle", 64'(busy), 64'd0);

        // Back-to-back with start held high: 18-edge period
        mp = 32'd2;
        mc = 32'hFFFFFFFD;
        start = 1'b1;
        sb_q.push_back(model(32'd2, 32'hFFFFFFFD, 1'b0));
        sb_q.push_back(model(32'd2, 32'hFFFFFFFD, 1'b0));
        cnt = 0;
        while (!done && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        check("b2b_first", {HI, LO}, exp);
        gap = 0;
        do begin
            @(negedge clock);
            gap++;
        end while (!done && gap < 40);
        start = 1'b0;
        check("b2b_gap", 64'(gap), 64'd18);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        check("b2b_second", {HI, LO}, exp);
        repeat (3) @(negedge clock);
        check("b2b_stopped", 64'(busy), 64'd0);

`ifdef UNSIGNED_MUL_EN
        run_op("multu", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 18);
        check("multu_const", {HI, LO}, 64'hFFFFFFFE00000001);
        run_op("mult_s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 17);
        check("mult_s_const", {HI, LO}, 64'h1);
        for (int i = 0; i < 4; i++) run_op("urand", $urandom, $urandom, 1'b1, 1'b0, 18);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential radix-4 Booth signed multiplier for the MUL datapath path.
- Takes two 32-bit operands and produces a 64-bit product split into HI (upper 32 bits) and LO (lower 32 bits).
- Complements the non-restoring divider: same operand convention (mp, mc) and same HI/LO result registers.
- Sits beside the divider in the ALU and is controlled with a start/done handshake from the control unit.

Parameters:
- WIDTH, 32, operand width. Must be even. Product is 2*WIDTH bits.
- ITER, WIDTH/2, number of radix-4 iterations. Derived; not overridden.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- mp  in  32  multiplier, two's complement
- mc  in  32  multiplicand, two's complement
- busy  out  1  high while the state is RUN
- done  out  1  one-cycle pulse; HI/LO valid from this cycle on
- HI  out  32  product[63:32]
- LO  out  32  product[31:0]

Behaviour:
- Clock and reset (already decided): one clock, `clock`; reset `clear` is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, HI=0, LO=0, iteration count=0, internal accumulator=0.
- IDLE:
  - When start=1 at a clock edge: latch mp and mc, clear the accumulator, set count=0, go to RUN.
  - When start=0: stay in IDLE.
- RUN, one Booth step per edge:
  - Examine the multiplier triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Add 0, ±mc or ±2mc to the accumulator.
  - Arithmetic shift right by 2.
  - count++.
- Datapath widths:
  - Accumulator upper half is 34 bits (WIDTH+2), sign-extended, so that ±2mc never overflows.
  - -mc is formed as ~mc+1 in 34 bits.
  - mc = 0x80000000 must give correct results (it has no positive counterpart in 32 bits).
- End of RUN: on the edge where count==ITER-1, perform the final step, load HI/LO from the accumulator, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditional transition to IDLE.
- Latency: start sampled at edge N; HI/LO updated at edge N+16; done is high during the cycle following edge N+16, i.e. 17 edges from the start edge to done falling.
- Result hold: HI/LO hold their value until the next completed operation or `clear`. They are never partially updated.
- start while in RUN or DONE: ignored; operands are not re-latched and no queued request is kept.
- Operand changes after the start edge: no effect on the result.
- `clear` mid-operation: immediate return to IDLE. busy=0, done=0, HI/LO=0. No done pulse follows.
- `clear` together with start: clear wins.
- Back-to-back operation: start held high continuously gives a new operation every 18 edges (IDLE re-entered for one cycle).

Optional Feature:
- Macro: UNSIGNED_MUL_EN
- Defined:
  - Adds input port is_unsigned (1 bit), latched at start.
  - When is_unsigned=1, operands are zero-extended to 34 bits and ITER becomes WIDTH/2+1 (17 steps). The product is the unsigned 64-bit result (MULTU).
  - done arrives one cycle later than the signed case: HI/LO updated at edge N+17.
  - When is_unsigned=0, behaviour and latency are identical to the signed-only build.
- Undefined: the is_unsigned port is absent and every operation is signed with 16 steps.

Test Plan:
- mp=0x00000000, mc=0x00000000, start pulse -> done exactly once after 16 RUN edges; HI=0x00000000, LO=0x00000000; busy high for 16 cycles.
- mp=0xFFFFFFFF, mc=0xFFFFFFFF (-1*-1) -> HI=0x00000000, LO=0x00000001.
- mp=0xFFFFFFFC, mc=0x00000002 (-4*2) -> HI=0xFFFFFFFF, LO=0xFFFFFFF8. Then mp=0x80000000, mc=0x80000000 -> HI=0x40000000, LO=0x00000000.
- Start 7*3 = 21 (HI=0, LO=0x15). Re-pulse start with mp=5 at RUN cycle 4 and change mc mid-run -> result still LO=0x00000015, single done pulse.
- Start 7*3 and assert `clear` asynchronously at RUN cycle 8 -> busy=0, HI/LO=0 immediately; no done for 20 cycles; next start of 7*3 -> LO=0x00000015.
- UNSIGNED_MUL_EN defined, is_unsigned=1, mp=mc=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done one cycle later than the signed case. Same operands with is_unsigned=0 -> HI=0, LO=1.
